// File: rtl/sd_wide_add_seq.sv
// Signed-digit wide adder sequencer: runs one shared BITS-digit adder slice over WORDS slices, LSB slice first.
// Latency: WORDS granted cycles after start; res_valid from cycle WORDS+1 when adder_gnt is held high.
// Backpressure: stalls on adder_gnt=0; holds the result on res_* until res_ready; start is taken only while ready.
// Optional abort input is enabled by defining SD_WIDE_ADD_ABORT_EN.
module sd_wide_add_seq #(
   parameter int BITS  = 4,
   parameter int WORDS = 4,
   parameter int IW    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef SD_WIDE_ADD_ABORT_EN
   input  logic                  abort,
`endif
   input  logic                  start,
   output logic                  ready,
   input  logic [WORDS*BITS-1:0] op_x_plus,
   input  logic [WORDS*BITS-1:0] op_x_minus,
   input  logic [WORDS*BITS-1:0] op_y_plus,
   input  logic [WORDS*BITS-1:0] op_y_minus,
   input  logic [1:0]            op_cin,
   output logic [WORDS*BITS-1:0] res_z_plus,
   output logic [WORDS*BITS-1:0] res_z_minus,
   output logic [1:0]            res_cout,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic                  adder_req,
   input  logic                  adder_gnt,
   output logic [BITS-1:0]       adder_x_plus,
   output logic [BITS-1:0]       adder_x_minus,
   output logic [BITS-1:0]       adder_y_plus,
   output logic [BITS-1:0]       adder_y_minus,
   output logic [1:0]            adder_cin,
   input  logic [BITS-1:0]       adder_z_plus,
   input  logic [BITS-1:0]       adder_z_minus,
   input  logic [1:0]            adder_cout
);

   localparam int N = WORDS * BITS;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // One redundant operand: positive and negative digit vectors side by side.
   typedef struct packed {
      logic [N-1:0] plus;
      logic [N-1:0] minus;
   } sd_vec_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [1:0]    carry;
   sd_vec_t       op_x;
   sd_vec_t       op_y;
   sd_vec_t       res_z;
   logic          abort_req;

`ifdef SD_WIDE_ADD_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign res_z_plus  = res_z.plus;
   assign res_z_minus = res_z.minus;

   // Present the current slice to the shared adder only while RUN owns it; zero otherwise.
   always_comb begin
      adder_x_plus  = '0;
      adder_x_minus = '0;
      adder_y_plus  = '0;
      adder_y_minus = '0;
      adder_cin     = '0;
      if (state == RUN) begin
         adder_x_plus  = op_x.plus[int'(idx)*BITS +: BITS];
         adder_x_minus = op_x.minus[int'(idx)*BITS +: BITS];
         adder_y_plus  = op_y.plus[int'(idx)*BITS +: BITS];
         adder_y_minus = op_y.minus[int'(idx)*BITS +: BITS];
         adder_cin     = carry;
      end
   end

   // Sequencer FSM: capture operands, walk slices on each grant, hold result until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= '0;
         op_x      <= '0;
         op_y      <= '0;
         res_z     <= '0;
         res_cout  <= '0;
         ready     <= 1'b1;
         res_valid <= 1'b0;
         adder_req <= 1'b0;
      end else if (abort_req && state != IDLE) begin
         // Abandon the operation; partially written result slices are left in place.
         state     <= IDLE;
         idx       <= '0;
         carry     <= '0;
         ready     <= 1'b1;
         res_valid <= 1'b0;
         adder_req <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start && ready) begin
                  op_x.plus  <= op_x_plus;
                  op_x.minus <= op_x_minus;
                  op_y.plus  <= op_y_plus;
                  op_y.minus <= op_y_minus;
                  carry      <= op_cin;
                  idx        <= '0;
                  state      <= RUN;
                  ready      <= 1'b0;
                  adder_req  <= 1'b1;
               end
            end
            RUN: begin
               if (adder_gnt) begin
                  res_z.plus[int'(idx)*BITS +: BITS]  <= adder_z_plus;
                  res_z.minus[int'(idx)*BITS +: BITS] <= adder_z_minus;
                  carry <= adder_cout;
                  if (idx == LAST) begin
                     res_cout  <= adder_cout;
                     state     <= DONE;
                     adder_req <= 1'b0;
                     res_valid <= 1'b1;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            DONE: begin
               // Returning through IDLE guarantees an idle cycle before the next start.
               if (res_ready) begin
                  state     <= IDLE;
                  res_valid <= 1'b0;
                  ready     <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_wide_add_seq.sv
// Testbench for sd_wide_add_seq: a WORDS=4 instance and a WORDS=1 instance, each with a stub slice adder.
// Reference: the stub passes X+ and Y- through and swaps the carry bits, so the full result is X+, Y-,
// and the final carry is op_cin swapped once per slice.
module tb_sd_wide_add_seq;

   localparam int BITS  = 4;
   localparam int WORDS = 4;
   localparam int N     = BITS * WORDS;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- WORDS=4 instance ----------------
   logic          abort = 1'b0;
   logic          start = 1'b0;
   logic          ready;
   logic [N-1:0]  op_x_plus = '0, op_x_minus = '0, op_y_plus = '0, op_y_minus = '0;
   logic [1:0]    op_cin = '0;
   logic [N-1:0]  res_z_plus, res_z_minus;
   logic [1:0]    res_cout;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic          adder_req;
   logic          adder_gnt = 1'b0;
   logic [BITS-1:0] adder_x_plus, adder_x_minus, adder_y_plus, adder_y_minus;
   logic [1:0]    adder_cin;
   logic [BITS-1:0] adder_z_plus, adder_z_minus;
   logic [1:0]    adder_cout;

   assign adder_z_plus  = adder_x_plus;
   assign adder_z_minus = adder_y_minus;
   assign adder_cout    = {adder_cin[0], adder_cin[1]};

   sd_wide_add_seq #(.BITS(BITS), .WORDS(WORDS), .IW(2)) dut (
      .clk(clk), .rst(rst),
`ifdef SD_WIDE_ADD_ABORT_EN
      .abort(abort),
`endif
      .start(start), .ready(ready),
      .op_x_plus(op_x_plus), .op_x_minus(op_x_minus), .op_y_plus(op_y_plus), .op_y_minus(op_y_minus),
      .op_cin(op_cin),
      .res_z_plus(res_z_plus), .res_z_minus(res_z_minus), .res_cout(res_cout),
      .res_valid(res_valid), .res_ready(res_ready),
      .adder_req(adder_req), .adder_gnt(adder_gnt),
      .adder_x_plus(adder_x_plus), .adder_x_minus(adder_x_minus),
      .adder_y_plus(adder_y_plus), .adder_y_minus(adder_y_minus),
      .adder_cin(adder_cin),
      .adder_z_plus(adder_z_plus), .adder_z_minus(adder_z_minus), .adder_cout(adder_cout)
   );

   // ---------------- WORDS=1 instance ----------------
   logic          abort1 = 1'b0;
   logic          start1 = 1'b0;
   logic          ready1;
   logic [BITS-1:0] op_x_plus1 = '0, op_x_minus1 = '0, op_y_plus1 = '0, op_y_minus1 = '0;
   logic [1:0]    op_cin1 = '0;
   logic [BITS-1:0] res_z_plus1, res_z_minus1;
   logic [1:0]    res_cout1;
   logic          res_valid1;
   logic          res_ready1 = 1'b0;
   logic          adder_req1;
   logic          adder_gnt1 = 1'b0;
   logic [BITS-1:0] adder_x_plus1, adder_x_minus1, adder_y_plus1, adder_y_minus1;
   logic [1:0]    adder_cin1;
   logic [BITS-1:0] adder_z_plus1, adder_z_minus1;
   logic [1:0]    adder_cout1;

   assign adder_z_plus1  = adder_x_plus1;
   assign adder_z_minus1 = adder_y_minus1;
   assign adder_cout1    = {adder_cin1[0], adder_cin1[1]};

   sd_wide_add_seq #(.BITS(BITS), .WORDS(1), .IW(1)) dut1 (
      .clk(clk), .rst(rst),
`ifdef SD_WIDE_ADD_ABORT_EN
      .abort(abort1),
`endif
      .start(start1), .ready(ready1),
      .op_x_plus(op_x_plus1), .op_x_minus(op_x_minus1), .op_y_plus(op_y_plus1), .op_y_minus(op_y_minus1),
      .op_cin(op_cin1),
      .res_z_plus(res_z_plus1), .res_z_minus(res_z_minus1), .res_cout(res_cout1),
      .res_valid(res_valid1), .res_ready(res_ready1),
      .adder_req(adder_req1), .adder_gnt(adder_gnt1),
      .adder_x_plus(adder_x_plus1), .adder_x_minus(adder_x_minus1),
      .adder_y_plus(adder_y_plus1), .adder_y_minus(adder_y_minus1),
      .adder_cin(adder_cin1),
      .adder_z_plus(adder_z_plus1), .adder_z_minus(adder_z_minus1), .adder_cout(adder_cout1)
   );

   // Single comparison point: counts every check and reports a mismatch.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Carry after k slices through the stub adder: each slice swaps the two bits.
   function automatic logic [1:0] carry_after(input logic [1:0] cin, input int k);
      return (k % 2 == 1) ? {cin[0], cin[1]} : cin;
   endfunction

   // One full operation on the WORDS=4 instance. stall bit c drops adder_gnt in RUN cycle c (cycle 1 = first slice).
   task automatic run_op(input logic [N-1:0] xp, input logic [N-1:0] xm, input logic [N-1:0] yp,
                         input logic [N-1:0] ym, input logic [1:0] cin, input logic [31:0] stall,
                         input int bp, input int exp_valid_cyc);
      int k;
      int cyc;
      @(negedge clk);
      check("idle_ready", ready, 1'b1);
      check("idle_req", adder_req, 1'b0);
      op_x_plus = xp; op_x_minus = xm; op_y_plus = yp; op_y_minus = ym; op_cin = cin;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      cyc = 1;
      while (k < WORDS && cyc < 40) begin
         check("run_req", adder_req, 1'b1);
         check("run_ready", ready, 1'b0);
         check("run_valid", res_valid, 1'b0);
         check("slice_x_plus", adder_x_plus, xp[k*BITS +: BITS]);
         check("slice_x_minus", adder_x_minus, xm[k*BITS +: BITS]);
         check("slice_y_plus", adder_y_plus, yp[k*BITS +: BITS]);
         check("slice_y_minus", adder_y_minus, ym[k*BITS +: BITS]);
         check("slice_cin", adder_cin, carry_after(cin, k));
         adder_gnt = (cyc < 32) ? !stall[cyc] : 1'b1;
         @(negedge clk);
         if (adder_gnt) k++;
         cyc++;
      end
      adder_gnt = 1'b0;
      check("run_bounded", k, WORDS);
      if (exp_valid_cyc > 0) check("valid_cycle", cyc, exp_valid_cyc);
      check("done_valid", res_valid, 1'b1);
      check("done_req", adder_req, 1'b0);
      check("done_slice_zero", adder_x_plus, '0);
      check("done_cin_zero", adder_cin, '0);
      check("res_z_plus", res_z_plus, xp);
      check("res_z_minus", res_z_minus, ym);
      check("res_cout", res_cout, carry_after(cin, WORDS));
      // Hold off the sink and try to start another operation meanwhile.
      for (int i = 0; i < bp; i++) begin
         start = 1'b1;
         op_x_plus = ~xp; op_y_minus = ~ym; op_cin = ~cin;
         @(negedge clk);
         check("bp_valid", res_valid, 1'b1);
         check("bp_ready", ready, 1'b0);
         check("bp_z_plus", res_z_plus, xp);
         check("bp_z_minus", res_z_minus, ym);
         check("bp_cout", res_cout, carry_after(cin, WORDS));
      end
      start = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("hs_valid", res_valid, 1'b0);
      check("hs_ready", ready, 1'b1);
      check("hs_req", adder_req, 1'b0);
      check("kept_z_plus", res_z_plus, xp);
      check("kept_z_minus", res_z_minus, ym);
   endtask

   initial begin
      logic [N-1:0] rx, rxm, ry, rym;
      logic [3:0]   r1x, r1y;

      // ---- reset state ----
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", ready, 1'b1);
      check("rst_valid", res_valid, 1'b0);
      check("rst_req", adder_req, 1'b0);
      check("rst_slice", adder_x_plus, '0);
      check("rst_cin", adder_cin, '0);
      check("rst_cout", res_cout, '0);
      check("rst_z", res_z_plus, '0);
      check("rst_ready1", ready1, 1'b1);

      // ---- test 1: basic add, grant always ----
      run_op(16'h4321, 16'h0000, 16'h0000, 16'h8765, 2'b01, 32'h0, 0, 5);

      // ---- test 2: grant low in cycles 2-3 ----
      run_op(16'h4321, 16'h0000, 16'h0000, 16'h8765, 2'b01, 32'h0000_000C, 0, 7);

      // ---- test 3: output backpressure for 5 cycles ----
      run_op(16'h4321, 16'h1111, 16'h2222, 16'h8765, 2'b01, 32'h0, 5, 5);

      // ---- test 4: reset while slice 2 is presented ----
      @(negedge clk);
      op_x_plus = 16'hA5C3; op_y_minus = 16'h3C5A; op_cin = 2'b10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      adder_gnt = 1'b1;
      repeat (2) @(negedge clk);
      check("pre_rst_slice2", adder_x_plus, 4'h5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      adder_gnt = 1'b0;
      check("mid_rst_ready", ready, 1'b1);
      check("mid_rst_req", adder_req, 1'b0);
      check("mid_rst_valid", res_valid, 1'b0);
      check("mid_rst_slice", adder_x_plus, '0);
      check("mid_rst_ym", adder_y_minus, '0);
      check("mid_rst_cin", adder_cin, '0);
      check("mid_rst_z", res_z_plus, '0);
      // Stay idle a few cycles: no spurious result appears.
      repeat (3) @(negedge clk);
      check("mid_rst_no_valid", res_valid, 1'b0);

      // ---- test 5: WORDS=1 instance ----
      for (int t = 0; t < 4; t++) begin
         r1x = 4'($urandom);
         r1y = 4'($urandom);
         @(negedge clk);
         check("w1_idle_ready", ready1, 1'b1);
         op_x_plus1 = r1x; op_y_minus1 = r1y; op_x_minus1 = ~r1x; op_y_plus1 = ~r1y;
         op_cin1 = (t == 0) ? 2'b10 : 2'($urandom);
         start1 = 1'b1;
         @(negedge clk);
         start1 = 1'b0;
         if (t == 1) begin
            adder_gnt1 = 1'b0;
            check("w1_stall_req", adder_req1, 1'b1);
            @(negedge clk);
         end
         check("w1_req", adder_req1, 1'b1);
         check("w1_slice", adder_x_plus1, r1x);
         check("w1_cin", adder_cin1, op_cin1);
         adder_gnt1 = 1'b1;
         @(negedge clk);
         adder_gnt1 = 1'b0;
         check("w1_valid", res_valid1, 1'b1);
         check("w1_req_off", adder_req1, 1'b0);
         check("w1_z_plus", res_z_plus1, r1x);
         check("w1_z_minus", res_z_minus1, r1y);
         check("w1_cout", res_cout1, {op_cin1[0], op_cin1[1]});
         res_ready1 = 1'b1;
         @(negedge clk);
         res_ready1 = 1'b0;
         check("w1_hs_valid", res_valid1, 1'b0);
         check("w1_hs_ready", ready1, 1'b1);
      end

`ifdef SD_WIDE_ADD_ABORT_EN
      // ---- test 6: abort while slice 1 is presented ----
      @(negedge clk);
      op_x_plus = 16'h9ABC; op_y_minus = 16'h1357; op_cin = 2'b01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      adder_gnt = 1'b1;
      @(negedge clk);
      check("pre_abort_slice1", adder_x_plus, 4'hB);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      adder_gnt = 1'b0;
      check("abort_ready", ready, 1'b1);
      check("abort_valid", res_valid, 1'b0);
      check("abort_req", adder_req, 1'b0);
      check("abort_slice", adder_x_plus, '0);
      check("abort_partial", res_z_plus[3:0], 4'hC);
      repeat (2) @(negedge clk);
      check("abort_no_valid", res_valid, 1'b0);
      run_op(16'h0F1E, 16'h0, 16'h0, 16'h2D3C, 2'b11, 32'h0, 1, 5);
`endif

      // ---- randomized operations with random stalls and backpressure ----
      for (int t = 0; t < 25; t++) begin
         rx  = N'($urandom);
         rxm = N'($urandom);
         ry  = N'($urandom);
         rym = N'($urandom);
         run_op(rx, rxm, ry, rym, 2'($urandom), $urandom & 32'h0000_0F5A & (32'h1 << $urandom_range(0, 11) | 32'h0000_0100),
                $urandom_range(0, 3), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
